// File: rtl/approx_mul_error_monitor_pkg.sv
// Shared definitions for the approximate-multiplier error monitor:
// FSM state encoding and product/error width helpers.
package approx_mul_error_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    function automatic int err_w(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/approx_mul_error_monitor_seq_shift_add_mul.sv
// Exact unsigned multiplier: radix-2 shift-add, one multiplier bit per cycle, LSB first.
// A start pulse loads operands; done pulses for one cycle once prod holds the final product.
module seq_shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign prod = acc_q;

endmodule

// File: rtl/approx_mul_error_monitor.sv
// Error monitor for an approximate multiplier: recomputes each exact product and
// keeps saturating statistics of the signed error exact - approx_p.
module approx_mul_error_monitor
    import approx_mul_error_monitor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   approx_p,
    output logic                 res_valid,
    output logic [2*WIDTH:0]     res_err,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [2*WIDTH-1:0]   max_abs_err,
    output logic [ACC_W-1:0]     sum_abs_err,
    output logic                 sat
);
    localparam int PROD_W = prod_w(WIDTH);
    localparam int ERR_W  = err_w(WIDTH);
    localparam int CW     = $clog2(WIDTH + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PROD_W-1:0]   approx_q, approx_d;
    logic                res_valid_q, res_valid_d;
    logic [ERR_W-1:0]    res_err_q, res_err_d;
    logic [CNT_W-1:0]    sample_count_q, sample_count_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [PROD_W-1:0]   max_q, max_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic                sat_q, sat_d;

    logic                mul_start;
    logic                mul_done;
    logic [PROD_W-1:0]   mul_prod;
    logic [ERR_W-1:0]    err;
    logic [ERR_W-1:0]    neg_err;
    logic [PROD_W-1:0]   abs_err;
    logic [ACC_W:0]      sum_ext;

    assign in_ready  = (state_q == ST_IDLE);
    assign mul_start = in_ready && in_valid && !clear;

    seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        err     = {1'b0, mul_prod} - {1'b0, approx_q};
        neg_err = -err;
        abs_err = err[ERR_W-1] ? neg_err[PROD_W-1:0] : err[PROD_W-1:0];
        sum_ext = {1'b0, sum_q} + (ACC_W + 1)'(abs_err);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        approx_d       = approx_q;
        res_valid_d    = 1'b0;
        res_err_d      = res_err_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        max_d          = max_q;
        sum_d          = sum_q;
        sat_d          = sat_q;
        if (clear) begin
            state_d        = ST_IDLE;
            res_err_d      = '0;
            sample_count_d = '0;
            err_count_d    = '0;
            max_d          = '0;
            sum_d          = '0;
            sat_d          = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d  = ST_MUL;
                        cnt_d    = CW'(WIDTH - 1);
                        approx_d = approx_p;
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_UPDATE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_UPDATE: begin
                    state_d = ST_IDLE;
                    // mul_done always coincides with UPDATE; it guards against a stale product
                    if (mul_done) begin
                        res_valid_d = 1'b1;
                        res_err_d   = err;
                        if (sample_count_q == '1) begin
                            sat_d = 1'b1;
                        end else begin
                            sample_count_d = sample_count_q + CNT_W'(1);
                        end
                        if (err != '0) begin
                            if (err_count_q == '1) begin
                                sat_d = 1'b1;
                            end else begin
                                err_count_d = err_count_q + CNT_W'(1);
                            end
                        end
                        if (abs_err > max_q) begin
                            max_d = abs_err;
                        end
                        if (sum_ext[ACC_W]) begin
                            sum_d = '1;
                            sat_d = 1'b1;
                        end else begin
                            sum_d = sum_ext[ACC_W-1:0];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            approx_q       <= '0;
            res_valid_q    <= 1'b0;
            res_err_q      <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            max_q          <= '0;
            sum_q          <= '0;
            sat_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            approx_q       <= approx_d;
            res_valid_q    <= res_valid_d;
            res_err_q      <= res_err_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            max_q          <= max_d;
            sum_q          <= sum_d;
            sat_q          <= sat_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_err      = res_err_q;
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign max_abs_err  = max_q;
    assign sum_abs_err  = sum_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_approx_mul_error_monitor.sv
// Bench for approx_mul_error_monitor: a full-size instance and a narrow one
// (ACC_W=16, CNT_W=4) share stimulus and are checked every cycle against a statistics model.
module tb_approx_mul_error_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] approx_p = '0;

    logic        in_ready, res_valid, sat;
    logic [16:0] res_err;
    logic [15:0] sample_count, err_count, max_abs_err;
    logic [31:0] sum_abs_err;

    logic        in_ready_s, res_valid_s, sat_s;
    logic [16:0] res_err_s;
    logic [3:0]  sample_count_s, err_count_s;
    logic [15:0] max_abs_err_s, sum_abs_err_s;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    approx_mul_error_monitor #(.WIDTH(8), .ACC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx_p(approx_p), .res_valid(res_valid), .res_err(res_err),
        .sample_count(sample_count), .err_count(err_count), .max_abs_err(max_abs_err),
        .sum_abs_err(sum_abs_err), .sat(sat)
    );

    approx_mul_error_monitor #(.WIDTH(8), .ACC_W(16), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .approx_p(approx_p), .res_valid(res_valid_s), .res_err(res_err_s),
        .sample_count(sample_count_s), .err_count(err_count_s), .max_abs_err(max_abs_err_s),
        .sum_abs_err(sum_abs_err_s), .sat(sat_s)
    );

    typedef struct {
        longint sc;
        longint ec;
        longint mx;
        longint sum;
        bit     sat;
        longint err;
    } stats_t;

    stats_t m_big, m_small;
    stats_t zero_stats = '{sc: 0, ec: 0, mx: 0, sum: 0, sat: 0, err: 0};
    bit     m_busy = 1'b0;
    bit     m_valid = 1'b0;
    int     cyc = 0;
    int     done_at = 0;
    longint pa, pb, pp;

    function automatic stats_t upd(input stats_t s, input longint e, input longint cmax,
                                   input longint amax);
        longint ae;
        ae = (e < 0) ? -e : e;
        s.err = e;
        if (s.sc == cmax) s.sat = 1'b1; else s.sc++;
        if (e != 0) begin
            if (s.ec == cmax) s.sat = 1'b1; else s.ec++;
        end
        if (ae > s.mx) s.mx = ae;
        if (s.sum + ae > amax) begin
            s.sum = amax;
            s.sat = 1'b1;
        end else begin
            s.sum = s.sum + ae;
        end
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a sample accepted at edge k reports at edge k+9 unless rst/clear intervenes.
    initial begin
        m_big   = zero_stats;
        m_small = zero_stats;
        forever begin
            @(posedge clk);
            cyc++;
            m_valid = 1'b0;
            if (rst) begin
                m_busy  = 1'b0;
                m_big   = zero_stats;
                m_small = zero_stats;
            end else if (clear) begin
                m_busy  = 1'b0;
                m_big   = zero_stats;
                m_small = zero_stats;
            end else if (m_busy && cyc == done_at) begin
                m_big   = upd(m_big, pa * pb - pp, 65535, 64'd4294967295);
                m_small = upd(m_small, pa * pb - pp, 15, 65535);
                m_valid = 1'b1;
                m_busy  = 1'b0;
            end else if (!m_busy && in_valid) begin
                m_busy  = 1'b1;
                done_at = cyc + 9;
                pa = longint'(a);
                pb = longint'(b);
                pp = longint'(approx_p);
            end
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", longint'(in_ready), longint'(!m_busy));
                chk("res_valid", longint'(res_valid), longint'(m_valid));
                chk("res_err", longint'($signed(res_err)), m_big.err);
                chk("sample_count", longint'(sample_count), m_big.sc);
                chk("err_count", longint'(err_count), m_big.ec);
                chk("max_abs_err", longint'(max_abs_err), m_big.mx);
                chk("sum_abs_err", longint'(sum_abs_err), m_big.sum);
                chk("sat", longint'(sat), longint'(m_big.sat));
                chk("s_in_ready", longint'(in_ready_s), longint'(!m_busy));
                chk("s_res_valid", longint'(res_valid_s), longint'(m_valid));
                chk("s_res_err", longint'($signed(res_err_s)), m_small.err);
                chk("s_sample_count", longint'(sample_count_s), m_small.sc);
                chk("s_err_count", longint'(err_count_s), m_small.ec);
                chk("s_max_abs_err", longint'(max_abs_err_s), m_small.mx);
                chk("s_sum_abs_err", longint'(sum_abs_err_s), m_small.sum);
                chk("s_sat", longint'(sat_s), longint'(m_small.sat));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_wait", longint'(in_ready), 1);
    endtask

    task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] xp);
        wait_ready();
        a = xa;
        b = xb;
        approx_p = xp;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int lat;
        int nacc;
        int n;
        int lows;
        int pulses;
        int acc_cyc[3];

        @(negedge clk);
        chk_en = 1'b1;
        idle(2);
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_sample_count", longint'(sample_count), 0);
        chk("reset_res_valid", longint'(res_valid), 0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1
        send(8'd13, 8'd11, 16'd139);
        wait_result(lat);
        chk("t1_latency", lat, 9);
        chk("t1_res_err", longint'($signed(res_err)), 4);
        chk("t1_sample_count", longint'(sample_count), 1);
        chk("t1_err_count", longint'(err_count), 1);
        chk("t1_max", longint'(max_abs_err), 4);
        chk("t1_sum", longint'(sum_abs_err), 4);
        idle(1);

        // Test 2: exact result
        send(8'd255, 8'd255, 16'd65025);
        wait_result(lat);
        chk("t2_res_err", longint'($signed(res_err)), 0);
        chk("t2_sample_count", longint'(sample_count), 2);
        chk("t2_err_count", longint'(err_count), 1);
        chk("t2_sum", longint'(sum_abs_err), 4);
        idle(1);

        // Test 3: negative error
        send(8'd3, 8'd5, 16'd17);
        wait_result(lat);
        chk("t3_res_err_bits", longint'(res_err), 64'h1FFFE);
        chk("t3_max", longint'(max_abs_err), 4);
        chk("t3_sum", longint'(sum_abs_err), 6);
        idle(1);

        // Test 4: held in_valid, three back-to-back samples
        do_clear();
        chk("clear_sample_count", longint'(sample_count), 0);
        chk("clear_sum", longint'(sum_abs_err), 0);
        a = 8'd7;
        b = 8'd9;
        approx_p = 16'd60;
        wait_ready();
        in_valid = 1'b1;
        nacc = 0;
        n = 0;
        lows = 0;
        pulses = 0;
        while (nacc < 3 && n < 100) begin
            if (in_ready) begin
                acc_cyc[nacc] = n;
                nacc++;
            end else begin
                lows++;
            end
            if (res_valid) pulses++;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!in_ready) lows++;
            if (res_valid) pulses++;
            @(negedge clk);
        end
        chk("t4_accepts", nacc, 3);
        chk("t4_gap1", acc_cyc[1] - acc_cyc[0], 10);
        chk("t4_gap2", acc_cyc[2] - acc_cyc[1], 10);
        chk("t4_ready_low", lows, 27);
        chk("t4_pulses", pulses, 3);
        chk("t4_sample_count", longint'(sample_count), 3);
        chk("t4_sum", longint'(sum_abs_err), 9);

        // Test 5: clear 4 cycles into MUL, then the same with rst
        send(8'd13, 8'd11, 16'd139);
        idle(3);
        do_clear();
        chk("t5_in_ready", longint'(in_ready), 1);
        chk("t5_sample_count", longint'(sample_count), 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid) pulses++;
            @(negedge clk);
        end
        chk("t5_no_pulse", pulses, 0);
        send(8'd13, 8'd11, 16'd139);
        wait_result(lat);
        chk("t5_sum", longint'(sum_abs_err), 4);
        idle(1);
        send(8'd13, 8'd11, 16'd139);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5r_in_ready", longint'(in_ready), 1);
        chk("t5r_sum", longint'(sum_abs_err), 0);
        idle(12);
        send(8'd13, 8'd11, 16'd139);
        wait_result(lat);
        chk("t5r_sum_after", longint'(sum_abs_err), 4);
        idle(1);

        // A sample offered together with clear is not accepted
        a = 8'd2;
        b = 8'd2;
        approx_p = 16'd0;
        clear = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_hs_in_ready", longint'(in_ready), 1);
        idle(12);
        chk("clr_hs_sample_count", longint'(sample_count), 0);

        // Test 6: accumulator saturation on the narrow instance, then counter clamp
        send(8'd255, 8'd255, 16'd0);
        wait_result(lat);
        chk("t6_sum_s1", longint'(sum_abs_err_s), 65025);
        chk("t6_sat_s1", longint'(sat_s), 0);
        idle(1);
        send(8'd255, 8'd255, 16'd0);
        wait_result(lat);
        chk("t6_sum_s2", longint'(sum_abs_err_s), 65535);
        chk("t6_sat_s2", longint'(sat_s), 1);
        chk("t6_sum_big", longint'(sum_abs_err), 130050);
        chk("t6_sat_big", longint'(sat), 0);
        idle(1);
        for (int i = 0; i < 14; i++) begin
            send(8'd1, 8'd1, 16'd1);
            wait_result(lat);
            idle(1);
        end
        chk("t6_count_s_clamp", longint'(sample_count_s), 15);
        chk("t6_err_count_s", longint'(err_count_s), 2);
        chk("t6_sat_s_sticky", longint'(sat_s), 1);
        chk("t6_count_big", longint'(sample_count), 16);
        do_clear();
        chk("t6_sat_s_cleared", longint'(sat_s), 0);
        chk("t6_sum_s_cleared", longint'(sum_abs_err_s), 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
